// File: rtl/mem_port_arbiter_if.sv
// Unified memory port bundle: fetch and memory-stage requesters plus memory side.
// slave = arbiter view, master = requesters/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              IReqF;
  logic [ADDR_W-1:0] IAddrF;
  logic [DATA_W-1:0] IRdataF;
  logic              IReadyF;
  logic              DReqM;
  logic              DWeM;
  logic [ADDR_W-1:0] DAddrM;
  logic [DATA_W-1:0] DWdataM;
  logic [DATA_W-1:0] DRdataM;
  logic              DReadyM;
  logic              MemReq;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWdata;
  logic [DATA_W-1:0] MemRdata;
  logic              StallFetchF;
  logic              StallMemM;

  modport slave (
    input  IReqF, IAddrF, DReqM, DWeM, DAddrM, DWdataM, MemRdata,
    output IRdataF, IReadyF, DRdataM, DReadyM,
    output MemReq, MemWe, MemAddr, MemWdata,
    output StallFetchF, StallMemM
  );

  modport master (
    output IReqF, IAddrF, DReqM, DWeM, DAddrM, DWdataM, MemRdata,
    input  IRdataF, IReadyF, DRdataM, DReadyM,
    input  MemReq, MemWe, MemAddr, MemWdata,
    input  StallFetchF, StallMemM
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/memory-stage arbiter for the shared memory port, fixed-latency.
// Optional macro ARB_RR_EN: round-robin tie break instead of data priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_irdata;
  logic [DATA_W-1:0] r_drdata;
  logic              r_iready;
  logic              r_dready;

  logic w_i_elig;
  logic w_d_elig;
  logic w_gnt_d;
  logic w_gnt_i;

  // A requester completing this cycle is advancing, so its req is stale.
  always_comb begin
    w_i_elig = bus.IReqF & ~r_iready;
    w_d_elig = bus.DReqM & ~r_dready;
  end

`ifdef ARB_RR_EN
  logic r_last_d;

  // Tie goes to whoever was not granted last; reset favours data first.
  assign w_gnt_d = w_d_elig & (~w_i_elig | ~r_last_d);

  // Remember the side of every grant for the next tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (r_state == IDLE && (w_d_elig | w_i_elig)) begin
      r_last_d <= w_gnt_d;
    end
  end
`else
  assign w_gnt_d = w_d_elig;
`endif

  assign w_gnt_i = w_i_elig & ~w_gnt_d;

  // Grant, wait-state count, data capture and completion pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_irdata    <= '0;
      r_drdata    <= '0;
      r_iready    <= 1'b0;
      r_dready    <= 1'b0;
    end else begin
      r_mem_req <= 1'b0;
      r_iready  <= 1'b0;
      r_dready  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_gnt_d) begin
            r_state     <= BUSY_D;
            r_cnt       <= LAT;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.DWeM;
            r_mem_addr  <= bus.DAddrM;
            r_mem_wdata <= bus.DWdataM;
          end else if (w_gnt_i) begin
            r_state    <= BUSY_I;
            r_cnt      <= LAT;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= bus.IAddrF;
          end
        end
        BUSY_I: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_irdata <= bus.MemRdata;
            r_iready <= 1'b1;
            r_state  <= IDLE;
          end
        end
        BUSY_D: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (!r_mem_we) begin
              r_drdata <= bus.MemRdata;
            end
            r_dready <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.MemReq      = r_mem_req;
  assign bus.MemWe       = r_mem_we;
  assign bus.MemAddr     = r_mem_addr;
  assign bus.MemWdata    = r_mem_wdata;
  assign bus.IRdataF     = r_irdata;
  assign bus.IReadyF     = r_iready;
  assign bus.DRdataM     = r_drdata;
  assign bus.DReadyM     = r_dready;
  assign bus.StallFetchF = bus.IReqF & ~r_iready;
  assign bus.StallMemM   = bus.DReqM & ~r_dready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 and MEM_LAT=1 instances.
// Expected values are hand-computed per cycle.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b0.IReqF = 0; b0.IAddrF = 0; b0.DReqM = 0; b0.DWeM = 0;
    b0.DAddrM = 0; b0.DWdataM = 0; b0.MemRdata = 32'hBAD0BAD0;
    b1.IReqF = 0; b1.IAddrF = 0; b1.DReqM = 0; b1.DWeM = 0;
    b1.DAddrM = 0; b1.DWdataM = 0; b1.MemRdata = 32'hBAD0BAD0;
    reset = 1;
    tick(); tick();
    vectors++; if ({b0.MemReq, b0.MemWe, b0.IReadyF, b0.DReadyM} !== 4'b0) begin miscompares++; $display("FAIL rst_ctrl got %b exp 0000", {b0.MemReq, b0.MemWe, b0.IReadyF, b0.DReadyM}); end
    vectors++; if ({b0.MemAddr, b0.MemWdata} !== 64'h0) begin miscompares++; $display("FAIL rst_cmd got %h exp 0", {b0.MemAddr, b0.MemWdata}); end
    vectors++; if ({b0.IRdataF, b0.DRdataM} !== 64'h0) begin miscompares++; $display("FAIL rst_rdata got %h exp 0", {b0.IRdataF, b0.DRdataM}); end
    vectors++; if ({b1.MemReq, b1.IReadyF, b1.StallFetchF, b1.StallMemM} !== 4'b0) begin miscompares++; $display("FAIL rst_lat1 got %b exp 0000", {b1.MemReq, b1.IReadyF, b1.StallFetchF, b1.StallMemM}); end
    reset = 0;
  endtask

  task automatic test_fetch();
    tick();
    b0.IReqF = 1; b0.IAddrF = 32'h100; #1;
    vectors++; if ({b0.StallFetchF, b0.MemReq} !== 2'b10) begin miscompares++; $display("FAIL f_t0 stall/req got %b exp 10", {b0.StallFetchF, b0.MemReq}); end
    tick();
    vectors++; if ({b0.MemReq, b0.MemWe, b0.IReadyF, b0.StallFetchF} !== 4'b1001) begin miscompares++; $display("FAIL f_t1 ctrl got %b exp 1001", {b0.MemReq, b0.MemWe, b0.IReadyF, b0.StallFetchF}); end
    vectors++; if (b0.MemAddr !== 32'h100) begin miscompares++; $display("FAIL f_t1 addr got %h exp 100", b0.MemAddr); end
    tick();
    b0.MemRdata = 32'hE3A01005; #1;
    vectors++; if ({b0.MemReq, b0.IReadyF, b0.StallFetchF} !== 3'b001) begin miscompares++; $display("FAIL f_t2 ctrl got %b exp 001", {b0.MemReq, b0.IReadyF, b0.StallFetchF}); end
    vectors++; if (b0.MemAddr !== 32'h100) begin miscompares++; $display("FAIL f_t2 addr got %h exp 100", b0.MemAddr); end
    tick();
    b0.MemRdata = 32'hBAD0BAD0; #1;
    vectors++; if ({b0.IReadyF, b0.StallFetchF} !== 2'b10) begin miscompares++; $display("FAIL f_t3 ready/stall got %b exp 10", {b0.IReadyF, b0.StallFetchF}); end
    vectors++; if (b0.IRdataF !== 32'hE3A01005) begin miscompares++; $display("FAIL f_t3 rdata got %h exp e3a01005", b0.IRdataF); end
    b0.IReqF = 0;
    tick();
    vectors++; if ({b0.IReadyF, b0.MemReq} !== 2'b00) begin miscompares++; $display("FAIL f_t4 ready/req got %b exp 00", {b0.IReadyF, b0.MemReq}); end
  endtask

  task automatic test_priority();
    tick();
    b0.DReqM = 1; b0.DWeM = 0; b0.DAddrM = 32'h200;
    b0.IReqF = 1; b0.IAddrF = 32'h104;
    tick();
    vectors++; if ({b0.MemReq, b0.MemWe, b0.StallFetchF, b0.StallMemM} !== 4'b1011) begin miscompares++; $display("FAIL p_t1 ctrl got %b exp 1011", {b0.MemReq, b0.MemWe, b0.StallFetchF, b0.StallMemM}); end
    vectors++; if (b0.MemAddr !== 32'h200) begin miscompares++; $display("FAIL p_t1 addr got %h exp 200", b0.MemAddr); end
    tick();
    b0.MemRdata = 32'h11112222;
    tick();
    b0.MemRdata = 32'hBAD0BAD0; #1;
    vectors++; if ({b0.DReadyM, b0.StallMemM, b0.IReadyF, b0.MemReq} !== 4'b1000) begin miscompares++; $display("FAIL p_t3 ctrl got %b exp 1000", {b0.DReadyM, b0.StallMemM, b0.IReadyF, b0.MemReq}); end
    vectors++; if (b0.DRdataM !== 32'h11112222) begin miscompares++; $display("FAIL p_t3 drdata got %h exp 11112222", b0.DRdataM); end
    b0.DReqM = 0;
    tick();
    vectors++; if ({b0.MemReq, b0.DReadyM} !== 2'b10) begin miscompares++; $display("FAIL p_t4 req/dready got %b exp 10", {b0.MemReq, b0.DReadyM}); end
    vectors++; if (b0.MemAddr !== 32'h104) begin miscompares++; $display("FAIL p_t4 addr got %h exp 104", b0.MemAddr); end
    vectors++; if (b0.IRdataF !== 32'hE3A01005) begin miscompares++; $display("FAIL p_t4 irdata hold got %h exp e3a01005", b0.IRdataF); end
    tick();
    b0.MemRdata = 32'h33334444;
    tick();
    b0.MemRdata = 32'hBAD0BAD0; #1;
    vectors++; if (b0.IReadyF !== 1'b1) begin miscompares++; $display("FAIL p_t6 iready got %b exp 1", b0.IReadyF); end
    vectors++; if (b0.IRdataF !== 32'h33334444) begin miscompares++; $display("FAIL p_t6 irdata got %h exp 33334444", b0.IRdataF); end
    b0.IReqF = 0;
  endtask

  task automatic test_store();
    tick();
    b0.DReqM = 1; b0.DWeM = 1; b0.DAddrM = 32'h40; b0.DWdataM = 32'hDEADBEEF;
    tick();
    vectors++; if ({b0.MemReq, b0.MemWe} !== 2'b11) begin miscompares++; $display("FAIL s_t1 req/we got %b exp 11", {b0.MemReq, b0.MemWe}); end
    vectors++; if ({b0.MemAddr, b0.MemWdata} !== {32'h40, 32'hDEADBEEF}) begin miscompares++; $display("FAIL s_t1 addr/wdata got %h exp 00000040deadbeef", {b0.MemAddr, b0.MemWdata}); end
    tick();
    b0.MemRdata = 32'h55555555; #1;
    vectors++; if ({b0.MemReq, b0.MemWe, b0.DReadyM} !== 3'b010) begin miscompares++; $display("FAIL s_t2 ctrl got %b exp 010", {b0.MemReq, b0.MemWe, b0.DReadyM}); end
    vectors++; if (b0.MemWdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL s_t2 wdata got %h exp deadbeef", b0.MemWdata); end
    tick();
    vectors++; if (b0.DReadyM !== 1'b1) begin miscompares++; $display("FAIL s_t3 dready got %b exp 1", b0.DReadyM); end
    vectors++; if (b0.DRdataM !== 32'h11112222) begin miscompares++; $display("FAIL s_t3 drdata hold got %h exp 11112222", b0.DRdataM); end
    b0.DReqM = 0; b0.DWeM = 0;
    tick();
    vectors++; if (b0.DReadyM !== 1'b0) begin miscompares++; $display("FAIL s_t4 dready got %b exp 0", b0.DReadyM); end
  endtask

  task automatic test_reset_mid();
    tick();
    b0.DReqM = 1; b0.DWeM = 0; b0.DAddrM = 32'h80;
    tick();
    vectors++; if (b0.MemReq !== 1'b1) begin miscompares++; $display("FAIL r_t1 req got %b exp 1", b0.MemReq); end
    tick();
    reset = 1; b0.MemRdata = 32'h99990000;
    tick();
    vectors++; if ({b0.MemReq, b0.DReadyM, b0.StallMemM} !== 3'b001) begin miscompares++; $display("FAIL r_t3 ctrl got %b exp 001", {b0.MemReq, b0.DReadyM, b0.StallMemM}); end
    vectors++; if ({b0.MemAddr, b0.DRdataM, b0.IRdataF} !== 96'h0) begin miscompares++; $display("FAIL r_t3 regs got %h exp 0", {b0.MemAddr, b0.DRdataM, b0.IRdataF}); end
    reset = 0;
    tick();
    vectors++; if ({b0.MemReq, b0.DReadyM} !== 2'b10) begin miscompares++; $display("FAIL r_t4 req/dready got %b exp 10", {b0.MemReq, b0.DReadyM}); end
    vectors++; if (b0.MemAddr !== 32'h80) begin miscompares++; $display("FAIL r_t4 addr got %h exp 80", b0.MemAddr); end
    tick();
    b0.MemRdata = 32'h77778888;
    tick();
    b0.MemRdata = 32'hBAD0BAD0; #1;
    vectors++; if ({b0.DReadyM, b0.DRdataM} !== {1'b1, 32'h77778888}) begin miscompares++; $display("FAIL r_t6 dready/drdata got %h exp 177778888", {b0.DReadyM, b0.DRdataM}); end
    b0.DReqM = 0;
  endtask

  task automatic test_lat1();
    tick();
    b1.IReqF = 1; b1.IAddrF = 32'h0; #1;
    vectors++; if (b1.StallFetchF !== 1'b1) begin miscompares++; $display("FAIL l1_t0 stall got %b exp 1", b1.StallFetchF); end
    tick();
    b1.MemRdata = 32'hA0A0A0A0; #1;
    vectors++; if ({b1.MemReq, b1.MemAddr} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL l1_t1 req/addr got %h exp 100000000", {b1.MemReq, b1.MemAddr}); end
    tick();
    b1.MemRdata = 32'hBAD0BAD0; #1;
    vectors++; if ({b1.IReadyF, b1.MemReq, b1.IRdataF} !== {2'b10, 32'hA0A0A0A0}) begin miscompares++; $display("FAIL l1_t2 ready/data got %h exp 2a0a0a0a0", {b1.IReadyF, b1.MemReq, b1.IRdataF}); end
    b1.IAddrF = 32'h4;
    tick();
    vectors++; if ({b1.IReadyF, b1.MemReq} !== 2'b00) begin miscompares++; $display("FAIL l1_t3 ready/req got %b exp 00", {b1.IReadyF, b1.MemReq}); end
    tick();
    b1.MemRdata = 32'hB4B4B4B4; #1;
    vectors++; if ({b1.MemReq, b1.MemAddr} !== {1'b1, 32'h4}) begin miscompares++; $display("FAIL l1_t4 req/addr got %h exp 100000004", {b1.MemReq, b1.MemAddr}); end
    tick();
    vectors++; if ({b1.IReadyF, b1.IRdataF} !== {1'b1, 32'hB4B4B4B4}) begin miscompares++; $display("FAIL l1_t5 ready/data got %h exp 1b4b4b4b4", {b1.IReadyF, b1.IRdataF}); end
    b1.IReqF = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_addr;
    int grants;
`ifdef ARB_RR_EN
    exp_addr = 32'h400;
`else
    exp_addr = 32'h300;
`endif
    grants = 0;
    tick();
    b0.DReqM = 1; b0.DWeM = 0; b0.DAddrM = 32'h300;
    b0.IReqF = 1; b0.IAddrF = 32'h400;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (b0.MemReq === 1'b1) begin
        vectors++;
        if (b0.MemAddr !== exp_addr) begin miscompares++; $display("FAIL b2b grant%0d addr got %h exp %h", grants, b0.MemAddr, exp_addr); end
        exp_addr = (exp_addr == 32'h300) ? 32'h400 : 32'h300;
        grants++;
      end
    end
    b0.DReqM = 0; b0.IReqF = 0;
    vectors++; if (grants !== 4) begin miscompares++; $display("FAIL b2b grant count got %0d exp 4", grants); end
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_tie();
    logic [31:0] exp_addr;
`ifdef ARB_RR_EN
    exp_addr = 32'h400;
`else
    exp_addr = 32'h300;
`endif
    tick();
    b0.DReqM = 1; b0.DAddrM = 32'h300;
    b0.IReqF = 1; b0.IAddrF = 32'h400;
    tick();
    vectors++; if ({b0.MemReq, b0.MemAddr} !== {1'b1, exp_addr}) begin miscompares++; $display("FAIL tie grant got %h exp %h", {b0.MemReq, b0.MemAddr}, {1'b1, exp_addr}); end
    b0.DReqM = 0; b0.IReqF = 0;
    tick(); tick(); tick();
    vectors++; if ({b0.MemReq, b0.IReadyF, b0.DReadyM} !== 3'b000) begin miscompares++; $display("FAIL tie drain got %b exp 000", {b0.MemReq, b0.IReadyF, b0.DReadyM}); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_reset_mid();
    test_lat1();
    test_back_to_back();
    test_tie();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
